pc_gen: RTL and testbench

Parametrised program-counter generator for the RISC-V unicycle core. It replaces the fixed +1 counter with a configurable reset vector and step, plus prioritised redirects: branch, jump, trap and mret. It also provides stall hold, a boot bubble, an exception-PC register and misaligned-target detection. The block sits at the head of fetch and drives the instruction-memory address every cycle.

---
 rtl/pc_gen.sv | 102 ++++++++++
 tb/tb_pc_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator at the head of fetch.
// Provides a reset vector and a sequential step, plus prioritised trap/mret/jump/branch redirects.
// Also provides stall hold, a one-cycle boot bubble, epc capture and misaligned-target trapping.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int              STEP         = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic            mret,
  output logic [XLEN-1:0] pc_reg,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign
);

  localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
  // Low target bits that must be zero; an all-zero mask disables the check.
  localparam logic [XLEN-1:0] ALIGN_MASK =
    (ALIGN_BITS == 0) ? '0 : ((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

  typedef enum logic {BOOT, RUN} state_t;

  state_t state, state_nxt;
  logic   take_trap;
  logic   misalign_nxt;

  function automatic logic is_misaligned(input logic [XLEN-1:0] target);
    return |(target & ALIGN_MASK);
  endfunction

  assign pc_valid = (state == RUN);

  // Next-state and next-PC selection; BOOT ignores every redirect and holds the PC.
  always_comb begin
    state_nxt    = state;
    pc_next      = pc_reg;
    take_trap    = 1'b0;
    misalign_nxt = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (trap) begin
          take_trap = 1'b1;
        end else if (mret) begin
          pc_next = epc;
        end else if (stall) begin
          pc_next = pc_reg;
        end else if (jump) begin
          if (is_misaligned(jump_target)) begin
            take_trap    = 1'b1;
            misalign_nxt = 1'b1;
          end else begin
            pc_next = jump_target;
          end
        end else if (branch_taken) begin
          if (is_misaligned(branch_target)) begin
            take_trap    = 1'b1;
            misalign_nxt = 1'b1;
          end else begin
            pc_next = branch_target;
          end
        end else begin
          // Wraps modulo 2^XLEN without any flag.
          pc_next = pc_reg + STEP_X;
        end
        if (take_trap) pc_next = TRAP_VECTOR;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // State register; reset always re-enters BOOT.
  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  // PC, exception PC and misalignment pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg   <= RESET_VECTOR;
      epc      <= '0;
      misalign <= 1'b0;
    end else begin
      pc_reg   <= pc_next;
      misalign <= misalign_nxt;
      if (take_trap) epc <= pc_reg;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen with default parameters.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, trap, mret;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_reg, pc_next, epc;
  logic        pc_valid, misalign;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        trp;
    logic        mrt;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
  } obs_t;

  obs_t exp_q[$];

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .trap(trap), .mret(mret),
    .pc_reg(pc_reg), .pc_next(pc_next), .pc_valid(pc_valid),
    .epc(epc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(logic rst = 0, logic stl = 0, logic br = 0, logic [31:0] bt = 0,
                              logic j = 0, logic [31:0] jt = 0, logic trp = 0, logic mrt = 0);
    S.rst = rst; S.stl = stl; S.br = br; S.bt = bt;
    S.j = j; S.jt = jt; S.trp = trp; S.mrt = mrt;
  endfunction

  function automatic obs_t O(logic valid, logic [31:0] pc, logic [31:0] e, logic mis);
    O.valid = valid; O.pc = pc; O.epc = e; O.mis = mis;
  endfunction

  function automatic obs_t observed();
    return O(pc_valid, pc_reg, epc, misalign);
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; stall = s.stl; branch_taken = s.br; branch_target = s.bt;
    jump = s.j; jump_target = s.jt; trap = s.trp; mret = s.mrt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, g;
    // Reset must win over a simultaneous trap.
    apply(S(.rst(1), .trp(1), .j(1), .jt(32'h40)));
    exp_q.push_back(O(0, 32'h0, 32'h0, 0));
    step();
    e = exp_q.pop_front(); g = observed();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset_state got v=%0b pc=%h epc=%h mis=%0b want v=%0b pc=%h epc=%h mis=%0b",
               g.valid, g.pc, g.epc, g.mis, e.valid, e.pc, e.epc, e.mis);
    end
    // BOOT cycle: trap is ignored and pc_next holds.
    apply(S(.trp(1)));
    #1;
    checks++;
    if (pc_next !== 32'h0) begin
      errors++;
      $display("FAIL boot_pc_next got %h want %h", pc_next, 32'h0);
    end
    exp_q.push_back(O(1, 32'h0, 32'h0, 0));
    step();
    e = exp_q.pop_front(); g = observed();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL boot_exit got v=%0b pc=%h epc=%h mis=%0b want v=%0b pc=%h epc=%h mis=%0b",
               g.valid, g.pc, g.epc, g.mis, e.valid, e.pc, e.epc, e.mis);
    end
  endtask

  task automatic test_free_run();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(S()); x.push_back(O(1, 32'h4, 32'h0, 0));
    s.push_back(S()); x.push_back(O(1, 32'h8, 32'h0, 0));
    s.push_back(S()); x.push_back(O(1, 32'hC, 32'h0, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(x[i]); step();
      e = exp_q.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL free_run[%0d] got v=%0b pc=%h epc=%h mis=%0b want v=%0b pc=%h epc=%h mis=%0b",
                 i, g.valid, g.pc, g.epc, g.mis, e.valid, e.pc, e.epc, e.mis);
      end
    end
  endtask

  task automatic test_stall();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(S());                                x.push_back(O(1, 32'h10, 32'h0, 0));
    s.push_back(S(.stl(1)));                         x.push_back(O(1, 32'h10, 32'h0, 0));
    // Stall outranks a (misaligned) jump: no redirect, no misalign.
    s.push_back(S(.stl(1), .j(1), .jt(32'h41)));     x.push_back(O(1, 32'h10, 32'h0, 0));
    s.push_back(S(.stl(1)));                         x.push_back(O(1, 32'h10, 32'h0, 0));
    s.push_back(S());                                x.push_back(O(1, 32'h14, 32'h0, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(x[i]); step();
      e = exp_q.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL stall[%0d] got v=%0b pc=%h epc=%h mis=%0b want v=%0b pc=%h epc=%h mis=%0b",
                 i, g.valid, g.pc, g.epc, g.mis, e.valid, e.pc, e.epc, e.mis);
      end
    end
  endtask

  task automatic test_jump_branch();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(S(.j(1), .jt(32'h40), .br(1), .bt(32'h80))); x.push_back(O(1, 32'h40, 32'h0, 0));
    s.push_back(S(.br(1), .bt(32'h14)));                     x.push_back(O(1, 32'h14, 32'h0, 0));
    s.push_back(S());                                        x.push_back(O(1, 32'h18, 32'h0, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(x[i]); step();
      e = exp_q.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL jump_branch[%0d] got v=%0b pc=%h epc=%h mis=%0b want v=%0b pc=%h epc=%h mis=%0b",
                 i, g.valid, g.pc, g.epc, g.mis, e.valid, e.pc, e.epc, e.mis);
      end
    end
  endtask

  task automatic test_misalign();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(S(.br(1), .bt(32'h22))); x.push_back(O(1, 32'h100, 32'h18, 1));
    s.push_back(S());                    x.push_back(O(1, 32'h104, 32'h18, 0));
    s.push_back(S(.mrt(1)));             x.push_back(O(1, 32'h18, 32'h18, 0));
    s.push_back(S(.j(1), .jt(32'h1)));   x.push_back(O(1, 32'h100, 32'h18, 1));
    // Back-to-back misaligned redirects keep misalign high and refresh epc.
    s.push_back(S(.br(1), .bt(32'h6)));  x.push_back(O(1, 32'h100, 32'h100, 1));
    s.push_back(S());                    x.push_back(O(1, 32'h104, 32'h100, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(x[i]); step();
      e = exp_q.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL misalign[%0d] got v=%0b pc=%h epc=%h mis=%0b want v=%0b pc=%h epc=%h mis=%0b",
                 i, g.valid, g.pc, g.epc, g.mis, e.valid, e.pc, e.epc, e.mis);
      end
    end
  endtask

  task automatic test_trap();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(S(.j(1), .jt(32'h30)));             x.push_back(O(1, 32'h30, 32'h100, 0));
    s.push_back(S(.trp(1), .stl(1), .mrt(1)));      x.push_back(O(1, 32'h100, 32'h30, 0));
    s.push_back(S());                               x.push_back(O(1, 32'h104, 32'h30, 0));
    s.push_back(S(.trp(1)));                        x.push_back(O(1, 32'h100, 32'h104, 0));
    s.push_back(S(.mrt(1), .stl(1)));               x.push_back(O(1, 32'h104, 32'h104, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      if (i == 1) begin
        #1; checks++;
        if (pc_next !== 32'h100) begin
          errors++;
          $display("FAIL trap_pc_next got %h want %h", pc_next, 32'h100);
        end
      end
      exp_q.push_back(x[i]); step();
      e = exp_q.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL trap[%0d] got v=%0b pc=%h epc=%h mis=%0b want v=%0b pc=%h epc=%h mis=%0b",
                 i, g.valid, g.pc, g.epc, g.mis, e.valid, e.pc, e.epc, e.mis);
      end
    end
  endtask

  task automatic test_wrap_and_midrun_reset();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(S(.j(1), .jt(32'hFFFF_FFF8)));      x.push_back(O(1, 32'hFFFF_FFF8, 32'h104, 0));
    s.push_back(S());                               x.push_back(O(1, 32'hFFFF_FFFC, 32'h104, 0));
    s.push_back(S());                               x.push_back(O(1, 32'h0, 32'h104, 0));
    s.push_back(S());                               x.push_back(O(1, 32'h4, 32'h104, 0));
    s.push_back(S(.rst(1), .j(1), .jt(32'h40)));    x.push_back(O(0, 32'h0, 32'h0, 0));
    s.push_back(S(.j(1), .jt(32'h40)));             x.push_back(O(1, 32'h0, 32'h0, 0));
    s.push_back(S());                               x.push_back(O(1, 32'h4, 32'h0, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(x[i]); step();
      e = exp_q.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL wrap_reset[%0d] got v=%0b pc=%h epc=%h mis=%0b want v=%0b pc=%h epc=%h mis=%0b",
                 i, g.valid, g.pc, g.epc, g.mis, e.valid, e.pc, e.epc, e.mis);
      end
    end
  endtask

  initial begin
    apply(S(.rst(1)));
    @(negedge clk);
    test_reset();
    test_free_run();
    test_stall();
    test_jump_branch();
    test_misalign();
    test_trap();
    test_wrap_and_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
